// File: rtl/rx_frame_deframer.sv
// rx_frame_deframer: sits after the word aligner. Finds the header word,
// checks the descriptor, forwards payload words with sof/eof markers,
// checks the XOR trailer and reports one status pulse per frame. After
// cfg_bad_th consecutive bad events it asks the aligner to realign.
//
// Handshake: there is no backpressure. An input word is taken on any
// cycle with i_valid && i_bit_locked. An output beat exists on any cycle
// with o_valid high. o_stat_valid is a single-cycle pulse.
module rx_frame_deframer #(
  parameter int          W         = 32,
  parameter int          MAX_LEN   = 256,
  parameter int          REQ_HOLD  = 8,
  parameter logic [31:0] HDR_WORD  = 32'hEB94_BDA3,
  parameter logic [31:0] IDLE_WORD = 32'h0707_0707
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  input  logic         i_bit_locked,
  input  logic [3:0]   cfg_bad_th,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_sof,
  output logic         o_eof,
  output logic         o_stat_valid,
  output logic [1:0]   o_stat_code,
  output logic [7:0]   o_stat_seq,
  output logic         o_realign_req,
  output logic [15:0]  o_good_cnt,
  output logic [2:0]   o_dbg_state
);

  typedef enum logic [2:0] {
    S_HUNT        = 3'd0,
    S_DESC        = 3'd1,
    S_PAYLOAD     = 3'd2,
    S_TRAILER     = 3'd3,
    S_REALIGN     = 3'd4,
    S_WAIT_UNLOCK = 3'd5
  } state_t;

  state_t         state_q;
  logic [7:0]     seq_q;
  logic [15:0]    rem_q;
  logic           first_q;
  logic [W-1:0]   acc_q;
  logic [7:0]     exp_seq_q;
  logic           exp_valid_q;
  logic [3:0]     bad_cnt_q;
  logic [7:0]     hold_q;

  logic           accept;
  logic [15:0]    desc_len;
  logic           desc_ok;
  logic [3:0]     bad_inc;
  logic           bad_trip;
  logic           bad_ev;

  assign o_dbg_state = state_q;

  // Classify the current word: acceptance, descriptor validity, bad events.
  always_comb begin
    accept   = i_valid && i_bit_locked;
    desc_len = i_data[15:0];
    desc_ok  = (i_data[31:24] == 8'hA5) && (desc_len != 16'd0) &&
               (desc_len <= 16'(MAX_LEN));
    bad_inc  = (bad_cnt_q == 4'hF) ? 4'hF : bad_cnt_q + 4'd1;
    bad_trip = (cfg_bad_th != 4'd0) && (bad_inc >= cfg_bad_th);
    bad_ev   = 1'b0;
    if (accept) begin
      case (state_q)
        S_HUNT:    bad_ev = (i_data != HDR_WORD) && (i_data != IDLE_WORD);
        S_DESC:    bad_ev = !desc_ok;
        S_TRAILER: bad_ev = (i_data != acc_q);
        default:   bad_ev = 1'b0;
      endcase
    end
  end

  // Framing FSM with registered outputs; bad-event handling overrides the
  // normal next state when the threshold is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_HUNT;
      seq_q         <= 8'd0;
      rem_q         <= 16'd0;
      first_q       <= 1'b0;
      acc_q         <= '0;
      exp_seq_q     <= 8'd0;
      exp_valid_q   <= 1'b0;
      bad_cnt_q     <= 4'd0;
      hold_q        <= 8'd0;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_sof         <= 1'b0;
      o_eof         <= 1'b0;
      o_stat_valid  <= 1'b0;
      o_stat_code   <= 2'd0;
      o_stat_seq    <= 8'd0;
      o_realign_req <= 1'b0;
      o_good_cnt    <= 16'd0;
    end else begin
      o_valid       <= 1'b0;
      o_sof         <= 1'b0;
      o_eof         <= 1'b0;
      o_stat_valid  <= 1'b0;
      o_realign_req <= 1'b0;

      case (state_q)
        S_HUNT: begin
          if (accept && i_data == HDR_WORD) state_q <= S_DESC;
        end

        S_DESC: begin
          if (!i_bit_locked) begin
            // Lock lost before seq is known: abort reports seq 0.
            o_stat_valid <= 1'b1;
            o_stat_code  <= 2'd2;
            o_stat_seq   <= 8'd0;
            state_q      <= S_HUNT;
          end else if (accept) begin
            if (desc_ok) begin
              seq_q   <= i_data[23:16];
              rem_q   <= desc_len;
              first_q <= 1'b1;
              acc_q   <= '0;
              state_q <= S_PAYLOAD;
            end else begin
              state_q <= S_HUNT;
            end
          end
        end

        S_PAYLOAD: begin
          if (!i_bit_locked) begin
            o_stat_valid <= 1'b1;
            o_stat_code  <= 2'd2;
            o_stat_seq   <= seq_q;
            state_q      <= S_HUNT;
          end else if (accept) begin
            o_data  <= i_data;
            o_valid <= 1'b1;
            o_sof   <= first_q;
            o_eof   <= (rem_q == 16'd1);
            first_q <= 1'b0;
            acc_q   <= acc_q ^ i_data;
            rem_q   <= rem_q - 16'd1;
            if (rem_q == 16'd1) state_q <= S_TRAILER;
          end
        end

        S_TRAILER: begin
          if (!i_bit_locked) begin
            o_stat_valid <= 1'b1;
            o_stat_code  <= 2'd2;
            o_stat_seq   <= seq_q;
            state_q      <= S_HUNT;
          end else if (accept) begin
            o_stat_valid <= 1'b1;
            o_stat_seq   <= seq_q;
            state_q      <= S_HUNT;
            if (i_data != acc_q) begin
              o_stat_code <= 2'd1;
            end else begin
              o_stat_code <= (!exp_valid_q || seq_q == exp_seq_q) ? 2'd0 : 2'd3;
              o_good_cnt  <= o_good_cnt + 16'd1;
              exp_seq_q   <= seq_q + 8'd1;
              exp_valid_q <= 1'b1;
              bad_cnt_q   <= 4'd0;
            end
          end
        end

        S_REALIGN: begin
          if (hold_q == 8'd0) begin
            state_q <= S_WAIT_UNLOCK;
          end else begin
            hold_q        <= hold_q - 8'd1;
            o_realign_req <= 1'b1;
          end
        end

        S_WAIT_UNLOCK: begin
          if (!i_bit_locked) begin
            state_q     <= S_HUNT;
            exp_valid_q <= 1'b0;
          end
        end

        default: state_q <= S_HUNT;
      endcase

      // Bad events count up; reaching the threshold redirects to REALIGN
      // and raises the request on the same edge.
      if (bad_ev) begin
        if (bad_trip) begin
          state_q       <= S_REALIGN;
          bad_cnt_q     <= 4'd0;
          hold_q        <= 8'(REQ_HOLD - 1);
          o_realign_req <= 1'b1;
        end else begin
          bad_cnt_q <= bad_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_deframer.sv
// Directed bench for rx_frame_deframer: payload beats and status pulses are
// matched against expected queues filled by the stimulus tasks.
module tb_rx_frame_deframer;

  localparam logic [31:0] HDR  = 32'hEB94_BDA3;
  localparam logic [31:0] IDLE = 32'h0707_0707;
  localparam logic [2:0]  ST_HUNT = 3'd0, ST_WAIT = 3'd5;

  logic        clk, rst;
  logic [31:0] i_data;
  logic        i_valid, i_bit_locked;
  logic [3:0]  cfg_bad_th;
  logic [31:0] o_data;
  logic        o_valid, o_sof, o_eof, o_stat_valid, o_realign_req;
  logic [1:0]  o_stat_code;
  logic [7:0]  o_stat_seq;
  logic [15:0] o_good_cnt;
  logic [2:0]  o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cycles = 0;

  logic [33:0] exp_q[$];       // {sof, eof, data}
  logic [9:0]  stat_exp_q[$];  // {code, seq}
  logic [31:0] pay_q[$];

  rx_frame_deframer dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .i_bit_locked(i_bit_locked), .cfg_bad_th(cfg_bad_th),
    .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof),
    .o_stat_valid(o_stat_valid), .o_stat_code(o_stat_code),
    .o_stat_seq(o_stat_seq), .o_realign_req(o_realign_req),
    .o_good_cnt(o_good_cnt), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: compare every beat / status pulse as it appears
  always @(negedge clk) begin
    if (!rst) begin
      if (o_realign_req) req_cycles++;
      if (o_valid) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 64'(o_valid), 64'd0);
        else chk("beat", {30'd0, o_sof, o_eof, o_data}, 64'(exp_q.pop_front()));
      end
      if (o_stat_valid) begin
        if (stat_exp_q.size() == 0) chk("stat_unexpected", 64'(o_stat_valid), 64'd0);
        else chk("stat", 64'({o_stat_code, o_stat_seq}), 64'(stat_exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic put(input logic [31:0] d, input logic v, input logic l);
    @(negedge clk);
    i_data = d; i_valid = v; i_bit_locked = l;
  endtask

  task automatic idle(input int n);
    repeat (n) put(IDLE, 1'b1, 1'b1);
  endtask

  // Sends HDR, descriptor, pay_q and trailer (optionally corrupted).
  task automatic send_frame(input logic [7:0] seq, input logic corrupt);
    logic [31:0] x;
    int n;
    x = 32'd0;
    n = pay_q.size();
    put(HDR, 1'b1, 1'b1);
    put({8'hA5, seq, 16'(n)}, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == 0), (i == n - 1), pay_q[i]});
      put(pay_q[i], 1'b1, 1'b1);
      x = x ^ pay_q[i];
    end
    put(corrupt ? (x ^ 32'd1) : x, 1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b1; i_data = '0; i_valid = 1'b0; i_bit_locked = 1'b0; cfg_bad_th = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_stat", 64'(o_stat_valid), 64'd0);
    chk("rst_req", 64'(o_realign_req), 64'd0);
    chk("rst_good", 64'(o_good_cnt), 64'd0);
    chk("rst_state", 64'(o_dbg_state), 64'(ST_HUNT));
    rst = 1'b0;

    // basic frame seq 5, payload 1..4, trailer 4
    idle(3);
    pay_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    stat_exp_q.push_back({2'd0, 8'd5});
    send_frame(8'd5, 1'b0);
    idle(2);
    chk("good_after_f1", 64'(o_good_cnt), 64'd1);

    // len=1 frame: sof and eof on the same beat
    pay_q = '{32'hDEADBEEF};
    stat_exp_q.push_back({2'd0, 8'd6});
    send_frame(8'd6, 1'b0);
    idle(2);
    chk("good_after_len1", 64'(o_good_cnt), 64'd2);
    chk("no_req_yet", 64'(req_cycles), 64'd0);

    // two checksum errors with threshold 2 -> realign for 8 cycles
    cfg_bad_th = 4'd2;
    pay_q = '{32'h10, 32'h20};
    stat_exp_q.push_back({2'd1, 8'd7});
    send_frame(8'd7, 1'b1);
    idle(2);
    chk("req_after_one_bad", 64'(req_cycles), 64'd0);
    stat_exp_q.push_back({2'd1, 8'd7});
    send_frame(8'd7, 1'b1);
    idle(12);
    chk("req_hold_cycles", 64'(req_cycles), 64'd8);
    chk("state_wait_unlock", 64'(o_dbg_state), 64'(ST_WAIT));
    chk("good_after_bad", 64'(o_good_cnt), 64'd2);
    put(IDLE, 1'b1, 1'b0);
    put(IDLE, 1'b1, 1'b1);
    chk("state_hunt_resumed", 64'(o_dbg_state), 64'(ST_HUNT));

    // expected seq invalidated: seq 7 -> code 0, seq 9 -> code 3, seq 10 -> code 0
    pay_q = '{32'h5, 32'h6, 32'h7};
    stat_exp_q.push_back({2'd0, 8'd7});
    send_frame(8'd7, 1'b0);
    idle(1);
    pay_q = '{32'hA5A5_0000, 32'h0000_5A5A};
    stat_exp_q.push_back({2'd3, 8'd9});
    send_frame(8'd9, 1'b0);
    idle(1);
    pay_q = '{32'h1234_5678};
    stat_exp_q.push_back({2'd0, 8'd10});
    send_frame(8'd10, 1'b0);
    idle(2);
    chk("good_after_seq", 64'(o_good_cnt), 64'd5);

    // one bad word (bad_cnt=1), then lock drop mid-frame, then one more bad
    // word must reach threshold 2 because the abort left bad_cnt alone
    req_cycles = 0;
    put(32'h1111_2222, 1'b1, 1'b1);
    idle(1);
    put(HDR, 1'b1, 1'b1);
    put({8'hA5, 8'd11, 16'd6}, 1'b1, 1'b1);
    exp_q.push_back({1'b1, 1'b0, 32'hAAAA_0001});
    put(32'hAAAA_0001, 1'b1, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 32'hAAAA_0002});
    put(32'hAAAA_0002, 1'b1, 1'b1);
    stat_exp_q.push_back({2'd2, 8'd11});
    put(32'hAAAA_0003, 1'b1, 1'b0);
    put(IDLE, 1'b1, 1'b1);
    put(IDLE, 1'b1, 1'b1);
    chk("abort_no_req", 64'(req_cycles), 64'd0);
    chk("good_after_abort", 64'(o_good_cnt), 64'd5);
    put(32'h3333_4444, 1'b1, 1'b1);
    idle(12);
    chk("req_after_abort", 64'(req_cycles), 64'd8);
    put(IDLE, 1'b1, 1'b0);
    put(IDLE, 1'b1, 1'b1);
    chk("hunt_after_abort", 64'(o_dbg_state), 64'(ST_HUNT));

    // invalid descriptors with realign disabled
    cfg_bad_th = 4'd0;
    req_cycles = 0;
    put(HDR, 1'b1, 1'b1);
    put({8'hA5, 8'd12, 16'd0}, 1'b1, 1'b1);
    idle(1);
    chk("len0_hunt", 64'(o_dbg_state), 64'(ST_HUNT));
    put(HDR, 1'b1, 1'b1);
    put({8'hA5, 8'd13, 16'd257}, 1'b1, 1'b1);
    idle(1);
    chk("len257_hunt", 64'(o_dbg_state), 64'(ST_HUNT));
    idle(4);
    chk("baddesc_no_req", 64'(req_cycles), 64'd0);

    chk("beats_left", 64'(exp_q.size()), 64'd0);
    chk("stats_left", 64'(stat_exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
